// File: rtl/lui_writeback_sequencer_if.sv
// Writeback request, memory read and register-file write signals of the
// LUI writeback sequencer, bundled so the block and its environment share one bus.
interface lui_writeback_sequencer_if;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqType;
  logic [4:0]  reqDest;
  logic [15:0] reqImmediate;
  logic [31:0] reqAluResult;
  logic [31:0] reqAddress;
  logic        memRead;
  logic [31:0] memAddress;
  logic        memAck;
  logic [31:0] memoryData;
  logic        regWrite;
  logic [4:0]  regDest;
  logic [31:0] regData;
  logic        memError;
  logic        busy;

  // Sequencer side
  modport slave (
    input  reqValid, reqType, reqDest, reqImmediate, reqAluResult, reqAddress,
    input  memAck, memoryData,
    output reqReady, memRead, memAddress, regWrite, regDest, regData, memError, busy
  );

  // Decode/execute plus memory side
  modport master (
    output reqValid, reqType, reqDest, reqImmediate, reqAluResult, reqAddress,
    output memAck, memoryData,
    input  reqReady, memRead, memAddress, regWrite, regDest, regData, memError, busy
  );
endinterface

// File: rtl/lui_writeback_sequencer.sv
// Register-file writeback sequencer: forwards ALU results, builds LUI words and
// fetches load data over a timed-out memory read handshake.
module lui_writeback_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  lui_writeback_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic [1:0] T_ALU  = 2'b00;
  localparam logic [1:0] T_LUI  = 2'b01;
  localparam logic [1:0] T_LOAD = 2'b10;
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [31:0] mem_addr_p0;
  logic [4:0]  reg_dest_p0;
  logic [31:0] reg_data_p0;
  logic        mem_err_p0;
  logic        accept;
  logic        timeout_hit;

  function automatic logic [31:0] lui_word(input logic [15:0] imm);
    return {imm, 16'h0000};
  endfunction

  assign accept      = bus.reqValid && bus.reqReady;
  // Ack takes priority over a timeout landing on the same edge.
  assign timeout_hit = (state == MEM_WAIT) && !bus.memAck && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, WRITE: begin
        state_nxt = IDLE;
        if (bus.reqValid) begin
          unique case (bus.reqType)
            T_ALU, T_LUI: state_nxt = WRITE;
            T_LOAD:       state_nxt = MEM_WAIT;
            default:      state_nxt = IDLE;
          endcase
        end
      end
      MEM_WAIT: begin
        if (bus.memAck)        state_nxt = WRITE;
        else if (timeout_hit)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.reqReady = (state == IDLE) || (state == WRITE);
    bus.memRead  = (state == MEM_WAIT);
    bus.regWrite = (state == WRITE) && (reg_dest_p0 != 5'd0);
    bus.busy     = (state != IDLE);
  end

  // Stage p0: request/response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_p0 <= '0;
      reg_dest_p0 <= '0;
      reg_data_p0 <= '0;
      mem_err_p0  <= 1'b0;
      cnt         <= '0;
    end else begin
      mem_err_p0 <= timeout_hit;
      if (accept) begin
        unique case (bus.reqType)
          T_ALU: begin
            reg_data_p0 <= bus.reqAluResult;
            reg_dest_p0 <= bus.reqDest;
          end
          T_LUI: begin
            reg_data_p0 <= lui_word(bus.reqImmediate);
            reg_dest_p0 <= bus.reqDest;
          end
          T_LOAD: begin
            mem_addr_p0 <= bus.reqAddress;
            reg_dest_p0 <= bus.reqDest;
            cnt         <= '0;
          end
          default: ;
        endcase
      end else if (state == MEM_WAIT) begin
        if (bus.memAck)       reg_data_p0 <= bus.memoryData;
        else if (!timeout_hit) cnt        <= cnt + 8'd1;
      end
    end
  end

  assign bus.memAddress = mem_addr_p0;
  assign bus.regDest    = reg_dest_p0;
  assign bus.regData    = reg_data_p0;
  assign bus.memError   = mem_err_p0;

endmodule

// File: tb/tb_lui_writeback_sequencer.sv
// Scoreboard bench for lui_writeback_sequencer: expected writes are queued at
// request time and matched against every observed regWrite pulse.
module tb_lui_writeback_sequencer;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lui_writeback_sequencer_if bus();

  lui_writeback_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nchk = 0;
  int npass = 0;
  int nwr = 0, nrd = 0, nerr = 0, nrdy_wait = 0, cyc = 0;
  int wcyc[$];
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] t, input logic [4:0] d, input logic [15:0] imm,
                      input logic [31:0] alu, input logic [31:0] addr);
    bit ok;
    bus.reqValid = 1'b1;
    bus.reqType = t;
    bus.reqDest = d;
    bus.reqImmediate = imm;
    bus.reqAluResult = alu;
    bus.reqAddress = addr;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.reqReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 64'(bus.reqReady), 64'd1);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
  endtask

  task automatic load(input logic [4:0] d, input logic [31:0] addr, input logic [31:0] data,
                      input int ack_edge);
    int r0, e0;
    r0 = nrd;
    e0 = nerr;
    if (ack_edge > 0) exp_q.push_back({d, data});
    send(2'b10, d, 16'h0, 32'h0, addr);
    @(negedge clk);
    chk("mem_addr", 64'(bus.memAddress), 64'(addr));
    chk("ready_in_wait", 64'(bus.reqReady), 64'd0);
    chk("busy_in_wait", 64'(bus.busy), 64'd1);
    if (ack_edge > 0) begin
      repeat (ack_edge - 1) @(posedge clk);
      #1 bus.memAck = 1'b1;
      bus.memoryData = data;
      @(posedge clk);
      #1 bus.memAck = 1'b0;
      bus.memoryData = 32'h0;
    end else begin
      repeat (T) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("memread_cycles", 64'(nrd - r0), 64'((ack_edge > 0) ? ack_edge : T));
    chk("memerror_cycles", 64'(nerr - e0), 64'((ack_edge > 0) ? 0 : 1));
  endtask

  initial begin
    int w0, n0;
    reset = 1'b1;
    bus.reqValid = 1'b0;
    bus.reqType = 2'b00;
    bus.reqDest = 5'd0;
    bus.reqImmediate = 16'h0;
    bus.reqAluResult = 32'h0;
    bus.reqAddress = 32'h0;
    bus.memAck = 1'b0;
    bus.memoryData = 32'h0;

    fork
      forever begin
        logic [36:0] e;
        @(negedge clk);
        cyc++;
        if (!reset) begin
          if (bus.memRead) begin
            nrd++;
            if (bus.reqReady) nrdy_wait++;
          end
          if (bus.memError) nerr++;
          if (bus.regWrite) begin
            nwr++;
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 64'({bus.regDest, bus.regData}), 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("wr_dest", 64'(bus.regDest), 64'(e[36:32]));
              chk("wr_data", 64'(bus.regData), 64'(e[31:0]));
            end
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(bus.reqReady), 64'd1);
    chk("rst_memread", 64'(bus.memRead), 64'd0);
    chk("rst_memaddr", 64'(bus.memAddress), 64'd0);
    chk("rst_regwrite", 64'(bus.regWrite), 64'd0);
    chk("rst_regdest", 64'(bus.regDest), 64'd0);
    chk("rst_regdata", 64'(bus.regData), 64'd0);
    chk("rst_memerror", 64'(bus.memError), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ALU then LUI back-to-back
    w0 = wcyc.size();
    exp_q.push_back({5'd3, 32'h1234_5678});
    send(2'b00, 5'd3, 16'h0, 32'h1234_5678, 32'h0);
    exp_q.push_back({5'd4, 32'hFFFF_0000});
    send(2'b01, 5'd4, 16'hFFFF, 32'h0, 32'h0);
    exp_q.push_back({5'd31, 32'h8001_0000});
    send(2'b01, 5'd31, 16'h8001, 32'hDEAD_BEEF, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", 64'(wcyc.size() - w0), 64'd3);
    if (wcyc.size() - w0 >= 3) begin
      chk("b2b_gap1", 64'(wcyc[w0+1] - wcyc[w0]), 64'd1);
      chk("b2b_gap2", 64'(wcyc[w0+2] - wcyc[w0+1]), 64'd1);
    end

    // Loads: ack after 3, timeout, ack on the timeout edge, ack on first edge
    load(5'd5, 32'h0000_0040, 32'hAAA5_52A5, 3);
    n0 = nwr;
    load(5'd6, 32'h0000_1000, 32'h0, 0);
    chk("timeout_no_write", 64'(nwr - n0), 64'd0);
    load(5'd7, 32'h0000_2000, 32'h5A5A_0F0F, T);
    load(5'd8, 32'h0000_3000, 32'h0000_0001, 1);

    // Dest $zero is never written; next request proceeds
    n0 = nwr;
    send(2'b00, 5'd0, 16'h0, 32'hCAFE_F00D, 32'h0);
    exp_q.push_back({5'd9, 32'h0BAD_1DEA});
    send(2'b00, 5'd9, 16'h0, 32'h0BAD_1DEA, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_dest_writes", 64'(nwr - n0), 64'd1);

    // Reset mid-load, then a stale ack
    send(2'b10, 5'd10, 16'h0, 32'h0, 32'h0000_0080);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_memread", 64'(bus.memRead), 64'd0);
    chk("midrst_ready", 64'(bus.reqReady), 64'd1);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_memaddr", 64'(bus.memAddress), 64'd0);
    chk("midrst_regdest", 64'(bus.regDest), 64'd0);
    chk("midrst_regdata", 64'(bus.regData), 64'd0);
    chk("midrst_regwrite", 64'(bus.regWrite), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    n0 = nwr;
    @(posedge clk);
    #1 bus.memAck = 1'b1;
    bus.memoryData = 32'h1111_2222;
    @(posedge clk);
    #1 bus.memAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stale_ack_write", 64'(nwr - n0), 64'd0);

    // Reserved type and memAck while idle
    n0 = nwr;
    w0 = nrd;
    send(2'b11, 5'd12, 16'h1234, 32'h5555_AAAA, 32'h0000_0100);
    bus.memAck = 1'b1;
    @(posedge clk);
    #1 bus.memAck = 1'b0;
    @(negedge clk);
    chk("rsv_ready", 64'(bus.reqReady), 64'd1);
    chk("rsv_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rsv_writes", 64'(nwr - n0), 64'd0);
    chk("rsv_memread", 64'(nrd - w0), 64'd0);

    chk("ready_during_wait", 64'(nrdy_wait), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/lui_writeback_sequencer.md
# lui_writeback_sequencer

Sequences the register-file writeback path of the 32-bit MIPS datapath, including the LUI-versus-memory data selection. It accepts one writeback request at a time from decode/execute over a valid/ready handshake. Three request types are supported:
- ALU results are forwarded directly.
- LUI results are formed as `{immediate,16'h0000}`.
- Loads are fetched through a memory read handshake with a timeout.

It drives the single register-file write port.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles memRead stays asserted without memAck before the load is aborted (legal range 1–255).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request present
- reqReady  out  1  block can accept a request this cycle
- reqType  in  2  00 ALU, 01 LUI, 10 LOAD, 11 reserved (NOP)
- reqDest  in  5  destination register number
- reqImmediate  in  16  LUI immediate
- reqAluResult  in  32  ALU result
- reqAddress  in  32  load address
- memRead  out  1  memory read request, held until ack or timeout
- memAddress  out  32  registered load address
- memAck  in  1  read data valid on memoryData
- memoryData  in  32  memory read data
- regWrite  out  1  register-file write enable (one-cycle pulse)
- regDest  out  5  write register number
- regData  out  32  write data
- memError  out  1  one-cycle pulse on load timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MEM_WAIT, WRITE.
- reqReady = (state == IDLE) || (state == WRITE). A request is accepted on a rising edge with reqValid && reqReady. reqReady is low in MEM_WAIT.
- Accepting ALU: regData ← reqAluResult, regDest ← reqDest, go to WRITE.
- Accepting LUI: regData ← {reqImmediate,16'h0000}, regDest ← reqDest, go to WRITE.
- Accepting LOAD:
  - memAddress ← reqAddress, regDest ← reqDest, memRead ← 1, timeout counter ← 0, go to MEM_WAIT.
- Accepting reserved type 11: consumed with no write, go to IDLE.
- MEM_WAIT, each edge:
  - If memAck: regData ← memoryData, memRead ← 0, go to WRITE.
  - Else if the counter reaches MEM_TIMEOUT−1: memRead ← 0, memError ← 1 for one cycle, no write, go to IDLE.
  - Else: counter + 1.
- WRITE: regWrite = 1 for exactly this cycle, unless regDest == 0, in which case regWrite stays 0 ($zero is never written). Next state is IDLE, or a new acceptance proceeds as from IDLE.
- memAck in IDLE or WRITE is ignored.
- regDest, regData and memAddress hold their last value outside WRITE/MEM_WAIT.

## Timing
- Reset values, applied immediately on reset high: state IDLE, reqReady 1, memRead 0, memAddress 0, regWrite 0, regDest 0, regData 0, memError 0, busy 0, counter 0.
- ALU/LUI: accepted at edge E0 → regWrite high in cycle E0–E1. Latency 1; sustained throughput one write per cycle.
- LOAD:
  - Accepted at E0 → memRead high from E0.
  - memAck sampled at Ek (1 ≤ k ≤ MEM_TIMEOUT) → memRead low and regWrite high in cycle Ek–Ek+1, with regData equal to memoryData sampled at Ek.
- Timeout: no ack sampled at E1..E_MEM_TIMEOUT → at E_MEM_TIMEOUT memRead drops and memError pulses for one cycle. memRead is high for exactly MEM_TIMEOUT cycles.
- Ack and timeout on the same edge: ack wins, normal write, no memError.
- A request accepted in WRITE overlaps the current write. The new request's latched data appears only from the next edge, so the current regData/regDest are unaffected.
- Reset mid-load: memRead drops asynchronously and the load is discarded. A stale memAck arriving afterwards in IDLE is ignored.

## Test plan
- ALU then LUI back-to-back: reqAluResult=32'h1234_5678 dest 3, then LUI reqImmediate=16'hFFFF dest 4 on the next cycle → regWrite pulses on two consecutive cycles: (3, 32'h12345678), then (4, 32'hFFFF0000).
- Load with ack after 3 cycles: reqAddress=32'h0000_0040, memoryData=32'hAAA5_52A5 → memRead high for 3 cycles, memAddress 32'h40, then regWrite dest 5 with data 32'hAAA552A5. reqReady is low throughout MEM_WAIT.
- Load timeout with MEM_TIMEOUT=4 and memAck never asserted → memRead high for exactly 4 cycles, one-cycle memError, no regWrite, then back to IDLE. Repeat with memAck on the 4th edge → write occurs, no memError.
- Dest $zero: ALU request with dest 0 → no regWrite pulse, next request accepted normally.
- Reset mid-load: assert reset during MEM_WAIT → all outputs return to reset values immediately. memAck one cycle after reset release → no regWrite.
- Reserved type 11 and memAck pulsed while IDLE → no regWrite, no memRead, reqReady stays 1.
